// File: rtl/diff_obuft_pkg.sv
// rtl/diff_obuft_pkg.sv - shared constants for the differential tristate output wrapper
package diff_obuft_pkg;

    // Bit positions inside the 2-bit switch word
    localparam int SW_DATA = 0;
    localparam int SW_TRI  = 1;

    // Value loaded into the optional input register during reset: tristated, data low
    localparam logic [1:0] RST_SW = 2'b10;

endpackage

// File: rtl/diff_obuft_cell.sv
// rtl/diff_obuft_cell.sv - P/N tristate pad pair driven from one data bit and one enable
module diff_obuft_cell (
    input  logic     i,
    input  logic     t,
    output tri logic o,
    output tri logic ob
);

    // Only a clean 0 on t turns the driver on; X or Z on t leaves both legs floating
    logic drive;

    assign drive = (t === 1'b0);
    assign o     = drive ? i  : 1'bz;
    assign ob    = drive ? ~i : 1'bz;

endmodule

// File: rtl/diff_obuft_top.sv
// rtl/diff_obuft_top.sv - switch-driven differential tristate output with toggle diagnostics
module diff_obuft_top
    import diff_obuft_pkg::*;
#(
    parameter bit REG_IN = 1'b0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sw,
    output tri logic         diff_p,
    output tri logic         diff_n,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic eff_t;
    logic eff_d;
    logic prev_d;

    generate
        if (REG_IN) begin : g_reg
            logic [1:0] sw_q;

            // Register the switches once; reset parks the pads in high-Z
            always_ff @(posedge clk) begin
                if (rst) begin
                    sw_q <= RST_SW;
                end else begin
                    sw_q <= sw;
                end
            end

            assign eff_t = sw_q[SW_TRI];
            assign eff_d = sw_q[SW_DATA];
        end else begin : g_comb
            assign eff_t = sw[SW_TRI];
            assign eff_d = sw[SW_DATA];
        end
    endgenerate

    // Count data changes seen while driving; history tracks data even when floating
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_d     <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            prev_d <= eff_d;
            if (!eff_t && (eff_d != prev_d) && (toggle_cnt != CNT_MAX)) begin
                toggle_cnt <= toggle_cnt + CNT_W'(1);
            end
        end
    end

    diff_obuft_cell u_cell (
        .i  (eff_d),
        .t  (eff_t),
        .o  (diff_p),
        .ob (diff_n)
    );

endmodule

// File: tb/tb_diff_obuft_top.sv
// tb/tb_diff_obuft_top.sv - scoreboard bench for diff_obuft_top in three configurations
module tb_diff_obuft_top;

    typedef struct {
        int    cyc;
        int    dut;
        int    p;
        int    n;
        int    cnt;
        string name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0, rst1, rst2;
    logic [1:0]  sw0, sw1, sw2;
    wire         d0_p, d0_n, d1_p, d1_n, d2_p, d2_n;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    // pad codes: 0 = low, 1 = high, 2 = high-Z; indexed by sw value
    int ptab[4]   = '{0, 1, 2, 2};
    int ntab[4]   = '{1, 0, 2, 2};
    int cnt_a[11] = '{0, 0, 1, 1, 1, 2, 3, 3, 3, 4, 5};
    int cnt_c[7]  = '{0, 1, 2, 3, 3, 3, 3};

    diff_obuft_top #(.REG_IN(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst0), .sw(sw0), .diff_p(d0_p), .diff_n(d0_n), .toggle_cnt(cnt0)
    );
    diff_obuft_top #(.REG_IN(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst1), .sw(sw1), .diff_p(d1_p), .diff_n(d1_n), .toggle_cnt(cnt1)
    );
    diff_obuft_top #(.REG_IN(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .sw(sw2), .diff_p(d2_p), .diff_n(d2_n), .toggle_cnt(cnt2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string cs(input int c);
        return (c == 2) ? "z" : $sformatf("%0d", c);
    endfunction

    task automatic expect_out(input int dut, input int p, input int n, input int cnt, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.dut  = dut;
        e.p    = p;
        e.n    = n;
        e.cnt  = cnt;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // monitor: pop every expectation due this cycle and compare against the pads
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   pz, nz, ok_p, ok_n;
        int   pv, nv, acnt;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.dut)
                0: begin pz = (d0_p === 1'bz); nz = (d0_n === 1'bz); pv = int'(d0_p); nv = int'(d0_n); acnt = int'(cnt0); end
                1: begin pz = (d1_p === 1'bz); nz = (d1_n === 1'bz); pv = int'(d1_p); nv = int'(d1_n); acnt = int'(cnt1); end
                default: begin pz = (d2_p === 1'bz); nz = (d2_n === 1'bz); pv = int'(d2_p); nv = int'(d2_n); acnt = int'(cnt2); end
            endcase
            ok_p = (e.p == 2) ? pz : (!pz && pv == e.p);
            ok_n = (e.n == 2) ? nz : (!nz && nv == e.n);
            n_cmp++;
            if (!ok_p || !ok_n || acnt != e.cnt) begin
                n_bad++;
                $display("FAIL %s dut%0d cyc=%0d got p=%s n=%s cnt=%0d want p=%s n=%s cnt=%0d",
                         e.name, e.dut, cyc, pz ? "z" : $sformatf("%0d", pv), nz ? "z" : $sformatf("%0d", nv),
                         acnt, cs(e.p), cs(e.n), e.cnt);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog time limit reached, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        sw0 = 2'b00; sw1 = 2'b00; sw2 = 2'b00;
        tick;
        tick;
        expect_out(0, 0, 1, 0, "rst_d0");
        expect_out(1, 2, 2, 0, "rst_d1");
        expect_out(2, 0, 1, 0, "rst_d2");

        // combinational path: incrementing sw, counter only on enabled data changes
        tick;
        rst0 = 1'b0;
        sw0  = 2'b00;
        expect_out(0, 0, 1, 0, "a_start");
        for (int i = 1; i <= 10; i++) begin
            tick;
            sw0 = 2'(i % 4);
            expect_out(0, ptab[i % 4], ntab[i % 4], cnt_a[i], "a_step");
        end
        tick;
        sw0  = 2'b01;
        rst0 = 1'b1;
        expect_out(0, 1, 0, 5, "a_rst_pads");
        tick;
        expect_out(0, 1, 0, 0, "a_rst_cnt");
        rst0 = 1'b0;

        // registered path: one cycle latency, reset floats the pads
        tick;
        rst1 = 1'b0;
        sw1  = 2'b01;
        expect_out(1, 2, 2, 0, "b_first_z");
        tick;
        expect_out(1, 1, 0, 0, "b_latency");
        tick;
        sw1 = 2'b00;
        expect_out(1, 1, 0, 1, "b_cnt");
        tick;
        rst1 = 1'b1;
        expect_out(1, 0, 1, 1, "b_data0");
        tick;
        rst1 = 1'b0;
        expect_out(1, 2, 2, 0, "b_rst_z");
        tick;
        expect_out(1, 0, 1, 0, "b_resume");

        // narrow counter saturates at 3
        tick;
        rst2 = 1'b0;
        sw2  = 2'b01;
        expect_out(2, 1, 0, 0, "c_start");
        for (int i = 1; i <= 6; i++) begin
            tick;
            sw2 = (i % 2 == 0) ? 2'b01 : 2'b00;
            expect_out(2, (i % 2 == 0) ? 1 : 0, (i % 2 == 0) ? 0 : 1, cnt_c[i], "c_sat");
        end

        tick;
        tick;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
